regfile_writeback_buffer: RTL
=============================

REGFILE_WRITEBACK_BUFFER -- requirements
Module: regfile_writeback_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of queued writeback entries; power of two, at least 2.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid  input  1  producer offers a writeback result.
REQ-005 The block SHALL have port in_ready  output  1  buffer can accept the offered result this cycle.
REQ-006 The block SHALL have port in_rd  input  5  destination register index of the offered result.
REQ-007 The block SHALL have port in_data  input  32  result value.
REQ-008 The block SHALL have port rf_write_register  output  5  register-file write address.
REQ-009 The block SHALL have port rf_write_enable  output  1  register-file write strobe.
REQ-010 The block SHALL have port rf_write_data  output  32  register-file write data.
REQ-011 The block SHALL have ports fwd_reg1, fwd_reg2  input  5 each  register indices being read this cycle.
REQ-012 The block SHALL have ports fwd_hit1, fwd_hit2  output  1 each  a pending write to that index is queued.
REQ-013 The block SHALL have ports fwd_data1, fwd_data2  output  32 each  newest pending value for that index.
REQ-014 The block SHALL have port count  output  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-015 The buffer SHALL be a circular FIFO of DEPTH entries {rd, data}, with head and tail pointers wrapping modulo DEPTH.
REQ-016 in_ready SHALL be 1 exactly when rst_n=1 and count<DEPTH, and SHALL depend only on registered state, with no path from in_* or rf_*.
REQ-017 A transfer SHALL occur on a posedge where in_valid=1 and in_ready=1; in_rd/in_data are captured at that edge.
REQ-018 A transfer with in_rd=0 SHALL be consumed (handshake completes) but SHALL NOT be enqueued; count is unchanged by it.
REQ-019 While count>0, rf_write_enable SHALL be 1, and rf_write_register/rf_write_data SHALL equal the head entry, driven combinationally from registered state.
REQ-020 While count>0, the head entry SHALL be popped at every posedge, giving one register-file write per cycle with no stall input.
REQ-021 While count=0, rf_write_enable, rf_write_register and rf_write_data SHALL all be 0.
REQ-022 Latency: an entry accepted at edge N into an empty buffer SHALL appear on rf_* during cycle N+1 and be written at edge N+1; there is no same-cycle bypass from in_* to rf_*.
REQ-023 Push and pop on the same edge SHALL leave count unchanged; push only increments it, pop only decrements it.
REQ-024 When full (count=DEPTH), in_ready SHALL be 0 even though a pop occurs that edge; the slot reopens in the following cycle.
REQ-025 Writes SHALL reach rf_* in acceptance order; repeated writes to one index are all issued, oldest first.
REQ-026 fwd_hitK SHALL be 1 when fwd_regK≠0 and any queued entry has rd=fwd_regK, including the head entry being written this cycle.
REQ-027 fwd_dataK SHALL be the data of the youngest matching entry when fwd_hitK=1, and 0 otherwise.
REQ-028 Forwarding SHALL consider only queued entries, not the in_* transfer of the same cycle.
REQ-029 The forwarding outputs SHALL be combinational in fwd_regK and registered state.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear head, tail and count to 0, immediately forcing in_ready=0, rf_write_enable=0, rf_write_register=0, rf_write_data=0, fwd_hit1/2=0 and fwd_data1/2=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries without issuing their writes.
REQ-032 After rst_n deasserts, the first transfer SHALL be accepted at the first posedge with in_valid=1.
REQ-033 Entry storage content need not be reset; no output may expose it while count=0.

Verification
REQ-034 Single write: push rd=5, data=0xDEADBEEF into an empty buffer at edge N -> during cycle N+1 rf_write_enable=1, rf_write_register=5, rf_write_data=0xDEADBEEF; cycle N+2 rf_write_enable=0, count=0.
REQ-035 Fill/full: with DEPTH=4, push on 4 consecutive edges -> count peaks at 4 only if pops lag, never exceeds 4; with count=4, in_valid held -> in_ready=0 that cycle, and the transfer completes the next cycle.
REQ-036 r0 suppression: push rd=0, data=0x12345678 -> handshake completes, count unchanged, rf_write_enable never carries index 0.
REQ-037 Forwarding priority: queue rd=7/0x11 then rd=7/0x22, fwd_reg1=7 -> fwd_hit1=1, fwd_data1=0x22; fwd_reg2=0 -> fwd_hit2=0.
REQ-038 Wrap-around: stream 10 back-to-back writes to rd=1..10 -> rf_* issues them in order with data intact across pointer wrap.
REQ-039 Mid-operation reset: with 3 entries queued, drop rst_n asynchronously between edges -> all outputs 0 at once; after release, no stale write is issued.

Source files
------------

// File: rtl/regfile_writeback_buffer.sv
// Writeback buffer between result producers and the register file: a small FIFO that issues
// one register-file write per cycle and forwards the newest queued value for two read ports.
module regfile_writeback_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [31:0]              in_data,
  output logic [4:0]               rf_write_register,
  output logic                     rf_write_enable,
  output logic [31:0]              rf_write_data,
  input  logic [4:0]               fwd_reg1,
  input  logic [4:0]               fwd_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [31:0]              fwd_data1,
  output logic [31:0]              fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]      rd_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic            push;
  logic            pop;
  logic            not_empty;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty;
  // rst_n gates in_ready so it drops the instant reset asserts, not just at the next edge.
  assign in_ready  = rst_n & (count_q < CntW'(DEPTH));
  // Writes to r0 complete the handshake but are never queued.
  assign push      = in_valid & in_ready & (in_rd != 5'd0);
  assign count     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    if (push) begin
      tail_d = tail_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; every reader is qualified by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= in_rd;
      data_mem[tail_q] <= in_data;
    end
  end

  always_comb begin
    rf_write_enable   = 1'b0;
    rf_write_register = '0;
    rf_write_data     = '0;
    if (not_empty) begin
      rf_write_enable   = 1'b1;
      rf_write_register = rd_mem[head_q];
      rf_write_data     = data_mem[head_q];
    end
  end

  // Walk from head (oldest) to tail so a later match overrides an earlier one.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if ((fwd_reg1 != 5'd0) && (rd_mem[idx] == fwd_reg1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_mem[idx];
        end
        if ((fwd_reg2 != 5'd0) && (rd_mem[idx] == fwd_reg2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_mem[idx];
        end
      end
    end
  end

  count_bound_a : assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntW'(DEPTH));
  no_r0_write_a : assert property (@(posedge clk) disable iff (!rst_n)
                                   rf_write_enable |-> (rf_write_register != 5'd0));

endmodule
